uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmit path. It is the serializing counterpart of the UART Rx deserializer. It accepts a parallel word on a one-cycle valid strobe and emits a framed serial bit stream at one bit per CLK cycle (CLK is the TX baud clock). The frame is start, DATA_WIDTH data bits LSB first, optional parity, and stop. It sits between the TX-side async FIFO/pulse generator and the TX_OUT pin. Busy is returned upstream for flow control.

Parameters:
DATA_WIDTH, 8, width of the parallel data word and number of data bits per frame.

Ports:
CLK  input  1  TX baud clock; one serial bit per rising edge.
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  word to transmit; sampled only on acceptance.
Data_Valid  input  1  request strobe; accepted only in IDLE.
PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on acceptance.
TX_OUT  output  1  serial line; idles high.
Busy  output  1  high while a frame is in flight (START through STOP).

Behaviour:
- Clock and reset: one clock (CLK); reset RST is asynchronous and active-low. Reset forces state IDLE, TX_OUT=1, Busy=0, and clears the data, parity-config and bit-counter registers.
- TX_OUT and Busy are registered. Both reflect the state entered at each edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - If Data_Valid=1 at an edge: latch P_DATA, PAR_EN and PAR_TYP, clear the bit counter, and go to START.
  - Otherwise stay in IDLE.
- START: TX_OUT=0, Busy=1. Next state is DATA.
- DATA:
  - TX_OUT = latched_data[bit_cnt], Busy=1.
  - bit_cnt is $clog2(DATA_WIDTH) bits wide and increments each cycle.
  - When bit_cnt == DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY:
  - TX_OUT = (^latched_data) XOR latched PAR_TYP. This gives even parity (total ones even) for PAR_TYP=0 and odd parity for PAR_TYP=1.
  - Busy=1. Next state is STOP.
- STOP: TX_OUT=1, Busy=1. Next state is IDLE.
- Latency: Data_Valid sampled at edge k gives the start bit on TX_OUT from edge k. Data bit i is driven from edge k+1+i.
- Frame length: DATA_WIDTH+2 cycles with parity disabled, DATA_WIDTH+3 with parity enabled. This is followed by at least one IDLE cycle (TX_OUT=1, Busy=0) before the next start bit.
- Data_Valid while Busy=1 is ignored. It is not queued.
- Changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect on the current frame.
- If Data_Valid is held high continuously, a new frame is accepted on the first IDLE cycle. Frames therefore repeat with exactly one IDLE cycle between them.
- Parity is computed from the latched word, never from live P_DATA.
- Reset mid-frame: the line returns high and Busy drops asynchronously. The partial frame is abandoned and not resumed after reset release.
- Illegal or unused state encodings recover to IDLE on the next edge.

Test Plan:
1. Reset, then P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop). Busy high for 10 cycles, then TX_OUT=1 and Busy=0.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> 11-cycle frame; parity bit = 0 (four ones). Repeat with PAR_TYP=1 -> parity bit = 1.
3. P_DATA=0x00, PAR_EN=1, PAR_TYP=1 -> eight zero data bits, parity = 1, stop = 1.
4. Start 0x3C with no parity; at cycle 4 pulse Data_Valid with P_DATA=0xFF and change PAR_EN to 1 -> the frame still carries 0x3C with no parity bit; no second frame follows.
5. Hold Data_Valid=1 with P_DATA=0x81, PAR_EN=0 -> repeated frames of 10 Busy cycles separated by exactly one IDLE cycle with TX_OUT=1.
6. Assert RST low during data bit 3 of a 0x55 frame -> TX_OUT=1 and Busy=0 immediately. After release, the line stays idle until the next Data_Valid, and that frame is transmitted intact.

Source files
------------

// File: rtl/uart_tx.sv
// UART serializer: start, DATA_WIDTH bits LSB first, optional parity, stop; start bit on the accept edge.
// No queueing: Data_Valid is only honoured in IDLE, and Busy tells upstream to hold off.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
  logic                  accept;
  logic                  tx_nxt;
  logic                  busy_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      TX_OUT  <= tx_nxt;
      Busy    <= busy_nxt;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  always_comb begin
    state_nxt   = IDLE;
    bit_cnt_nxt = bit_cnt;
    accept      = 1'b0;
    tx_nxt      = 1'b1;
    busy_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (Data_Valid) begin
          accept      = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = START;
        end
      end
      START:   state_nxt = DATA;
      DATA: begin
        bit_cnt_nxt = bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
        else                     state_nxt = DATA;
      end
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_nxt)
      START: begin
        tx_nxt   = 1'b0;
        busy_nxt = 1'b1;
      end
      DATA: begin
        tx_nxt   = data_q[bit_cnt_nxt];
        busy_nxt = 1'b1;
      end
      PARITY: begin
        tx_nxt   = (^data_q) ^ par_typ_q;
        busy_nxt = 1'b1;
      end
      STOP: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b1;
      end
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: queue-of-frames reference model checked every cycle, plus directed scenarios.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry is the expected {TX_OUT, Busy} after one edge.
  logic [1:0] exp_q[$];
  logic       last_tx;
  logic       last_busy;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A frame as seen on the line: start, data LSB first, optional parity, stop,
  // then the mandatory idle cycle during which nothing can be accepted.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    logic par;
    par = logic'($countones(d) % 2) ^ pt;
    exp_q.push_back(2'b01);
    for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
    if (pe) exp_q.push_back({par, 1'b1});
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
  endtask

  task automatic step(input logic dv, input logic [7:0] d, input logic pe, input logic pt);
    logic [1:0] e;
    @(negedge CLK);
    Data_Valid = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    @(posedge CLK);
    if (exp_q.size() == 0 && dv) push_frame(d, pe, pt);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = 2'b10;
    #1;
    check_eq("tx_line", TX_OUT, e[1]);
    check_eq("busy", Busy, e[0]);
    last_tx   = TX_OUT;
    last_busy = Busy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic [10:0] seq;
  int          busy_cnt;
  int          run_len;
  int          gap_len;
  int          n_runs;
  logic        prev_busy;

  initial begin
    RST        = 1'b0;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #12;
    check_eq("reset_tx", TX_OUT, 1);
    check_eq("reset_busy", Busy, 0);
    @(negedge CLK);
    RST = 1'b1;
    idle(3);

    // 1: 0xA5 without parity, line sequence captured per cycle.
    seq = '0;
    busy_cnt = 0;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    seq[0] = last_tx;
    busy_cnt += int'(last_busy);
    for (int i = 1; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      seq[i] = last_tx;
      busy_cnt += int'(last_busy);
    end
    check_eq("a5_sequence", 32'(seq[9:0]), 32'b1101001010);
    check_eq("a5_busy_cycles", busy_cnt, 10);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("a5_after_tx", last_tx, 1);
    check_eq("a5_after_busy", last_busy, 0);
    idle(2);

    // 2: 0xA5 with even then odd parity; bit 9 of the frame is the parity bit.
    for (int t = 0; t < 2; t++) begin
      busy_cnt = 0;
      step(1'b1, 8'hA5, 1'b1, logic'(t));
      seq[0] = last_tx;
      busy_cnt += int'(last_busy);
      for (int i = 1; i < 11; i++) begin
        step(1'b0, 8'h00, 1'b0, 1'b0);
        seq[i] = last_tx;
        busy_cnt += int'(last_busy);
      end
      check_eq(t == 0 ? "a5_even_parity" : "a5_odd_parity", seq[9], t);
      check_eq("par_stop", seq[10], 1);
      check_eq("par_busy_cycles", busy_cnt, 11);
      idle(2);
    end

    // 3: all-zero word with odd parity.
    step(1'b1, 8'h00, 1'b1, 1'b1);
    seq[0] = last_tx;
    for (int i = 1; i < 11; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      seq[i] = last_tx;
    end
    check_eq("zero_frame", 32'(seq), 32'b11000000000);
    idle(2);

    // 4: requests and input changes mid-frame are ignored.
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) step(1'b0, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    for (int i = 5; i < 10; i++) step(1'b0, 8'hFF, 1'b1, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'hFF, 1'b1, 1'b1);
      busy_cnt += int'(last_busy);
    end
    check_eq("no_second_frame", busy_cnt, 0);

    // 5: Data_Valid held high gives back-to-back frames with one idle gap.
    run_len   = 0;
    gap_len   = 0;
    n_runs    = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step(1'b1, 8'h81, 1'b0, 1'b0);
      if (last_busy) begin
        if (!prev_busy && n_runs > 0) check_eq("held_gap", gap_len, 1);
        run_len++;
      end else begin
        if (prev_busy) begin
          check_eq("held_run", run_len, 10);
          n_runs++;
          gap_len = 0;
        end
        run_len = 0;
        gap_len++;
        check_eq("held_idle_line", last_tx, 1);
      end
      prev_busy = last_busy;
    end
    check_eq("held_runs", n_runs >= 3, 1);
    idle(12);

    // 6: reset during data bit 3 of 0x55.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    exp_q.delete();
    #1;
    check_eq("midrst_tx", TX_OUT, 1);
    check_eq("midrst_busy", Busy, 0);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    idle(5);
    seq = '0;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    seq[0] = last_tx;
    for (int i = 1; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      seq[i] = last_tx;
    end
    check_eq("post_rst_frame", 32'(seq[9:0]), 32'b1010101010);
    idle(2);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      step(logic'($urandom_range(0, 3) == 0), 8'($urandom), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)));
    end
    idle(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
